// File: rtl/sparsity_sched_ctrl_pkg.sv
// Shared state encodings and defaults for the sparsity scheduler and the layer control FSM.
package sparsity_sched_ctrl_pkg;

  localparam int CSN_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREAMBLE  = 3'd1,
    ST_ARM       = 3'd2,
    ST_INTEGRATE = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } sched_state_e;

endpackage

// File: rtl/sparsity_sched_ctrl_lane_popcount.sv
// Combinational count of non-sparse lanes in one sparsity mask beat.
module lane_popcount
  import sparsity_sched_ctrl_pkg::*;
#(
  parameter int CYCLE_SAMPLE_NUM = CSN_DEFAULT
) (
  input  logic [CYCLE_SAMPLE_NUM-1:0]       mask,
  output logic [$clog2(CYCLE_SAMPLE_NUM):0] count
);

  localparam int CW = $clog2(CYCLE_SAMPLE_NUM) + 1;

  always_comb begin
    count = '0;
    for (int i = 0; i < CYCLE_SAMPLE_NUM; i++) begin
      count = count + CW'(mask[i]);
    end
  end

endmodule

// File: rtl/sparsity_sched_ctrl.sv
// Per-layer sequencer: preamble count, integration over sparsity mask beats, drain, done.
module sparsity_sched_ctrl
  import sparsity_sched_ctrl_pkg::*;
#(
  parameter int CYCLE_SAMPLE_NUM = CSN_DEFAULT,
  parameter int DRAIN_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        layer_start,
  input  logic                        abort,
  input  logic [15:0]                 preamble_cycle_length,
  input  logic [15:0]                 integration_cycles,
  input  logic                        act_tvalid,
  input  logic                        wt_tvalid,
  input  logic [CYCLE_SAMPLE_NUM-1:0] sparsity_tdata,
  input  logic                        sparsity_tvalid,
  output logic                        state_changed,
  output logic                        integration_start,
  output logic [CYCLE_SAMPLE_NUM-1:0] lane_enable,
  output logic                        cycle_skip,
  output logic [31:0]                 nonzero_count,
  output logic [15:0]                 skip_count,
  output logic                        layer_done,
  output logic                        busy,
  output logic [1:0]                  err_flags
);

  localparam int PCW = $clog2(CYCLE_SAMPLE_NUM) + 1;
  localparam int DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [TW-1:0] IDLE_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  sched_state_e state_q, state_d;

  logic [15:0]                 pre_cnt_q, pre_cnt_d;
  logic [15:0]                 beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]               idle_cnt_q, idle_cnt_d;
  logic [DW-1:0]               drain_cnt_q, drain_cnt_d;
  logic [31:0]                 nonzero_count_q, nonzero_count_d;
  logic [15:0]                 skip_count_q, skip_count_d;
  logic [1:0]                  err_flags_q, err_flags_d;
  logic                        state_changed_q, state_changed_d;
  logic                        integration_start_q, integration_start_d;
  logic [CYCLE_SAMPLE_NUM-1:0] lane_enable_q, lane_enable_d;
  logic                        cycle_skip_q, cycle_skip_d;
  logic                        layer_done_q, layer_done_d;
  logic                        busy_q, busy_d;

  logic [PCW-1:0] pop;
  logic [15:0]    beat_target;
  logic           start_ok, beat, last_beat, timeout;

  lane_popcount #(.CYCLE_SAMPLE_NUM(CYCLE_SAMPLE_NUM)) u_popcount (
    .mask  (sparsity_tdata),
    .count (pop)
  );

  // Beats only count in INTEGRATE; an abort on the same cycle discards the beat.
  always_comb begin
    beat_target = (integration_cycles == 16'd0) ? 16'd1 : integration_cycles;
    start_ok    = (state_q == ST_IDLE) && layer_start && !abort;
    beat        = (state_q == ST_INTEGRATE) && sparsity_tvalid && !abort;
    last_beat   = beat && ((beat_cnt_q + 16'd1) == beat_target);
    timeout     = (state_q == ST_INTEGRATE) && !sparsity_tvalid && (idle_cnt_q == IDLE_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (layer_start) state_d = ST_PREAMBLE;
        ST_PREAMBLE:  if (pre_cnt_q == preamble_cycle_length) state_d = ST_ARM;
        ST_ARM:       state_d = ST_INTEGRATE;
        ST_INTEGRATE: begin
          if (last_beat)    state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
          else if (timeout) state_d = ST_DONE;
        end
        ST_DRAIN:     if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
        ST_DONE:      state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_cnt_d       = pre_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    idle_cnt_d      = idle_cnt_q;
    drain_cnt_d     = '0;
    nonzero_count_d = nonzero_count_q;
    skip_count_d    = skip_count_q;
    err_flags_d     = err_flags_q;
    if (start_ok) begin
      pre_cnt_d       = '0;
      beat_cnt_d      = '0;
      idle_cnt_d      = '0;
      nonzero_count_d = '0;
      skip_count_d    = '0;
    end
    if (state_q == ST_PREAMBLE && act_tvalid && wt_tvalid) pre_cnt_d = pre_cnt_q + 16'd1;
    if (state_q == ST_DRAIN) drain_cnt_d = drain_cnt_q + DW'(1);
    if (beat) begin
      beat_cnt_d      = beat_cnt_q + 16'd1;
      idle_cnt_d      = '0;
      nonzero_count_d = sat_add32(nonzero_count_q, 32'(pop));
      if (sparsity_tdata == '0) skip_count_d = sat_inc16(skip_count_q);
    end else if (state_q == ST_INTEGRATE && !abort) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end
    if (layer_start && state_q != ST_IDLE) err_flags_d[1] = 1'b1;
    if (timeout && !abort)                 err_flags_d[0] = 1'b1;
  end

  always_comb begin
    state_changed_d     = start_ok;
    integration_start_d = (state_q == ST_PREAMBLE) && (state_d == ST_ARM);
    lane_enable_d       = beat ? sparsity_tdata : '0;
    cycle_skip_d        = beat && (sparsity_tdata == '0);
    layer_done_d        = (state_d == ST_DONE);
    busy_d              = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q       <= '0;
      beat_cnt_q      <= '0;
      idle_cnt_q      <= '0;
      drain_cnt_q     <= '0;
      nonzero_count_q <= '0;
      skip_count_q    <= '0;
      err_flags_q     <= '0;
    end else begin
      pre_cnt_q       <= pre_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      nonzero_count_q <= nonzero_count_d;
      skip_count_q    <= skip_count_d;
      err_flags_q     <= err_flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_changed_q     <= 1'b0;
      integration_start_q <= 1'b0;
      lane_enable_q       <= '0;
      cycle_skip_q        <= 1'b0;
      layer_done_q        <= 1'b0;
      busy_q              <= 1'b0;
    end else begin
      state_changed_q     <= state_changed_d;
      integration_start_q <= integration_start_d;
      lane_enable_q       <= lane_enable_d;
      cycle_skip_q        <= cycle_skip_d;
      layer_done_q        <= layer_done_d;
      busy_q              <= busy_d;
    end
  end

  assign state_changed     = state_changed_q;
  assign integration_start = integration_start_q;
  assign lane_enable       = lane_enable_q;
  assign cycle_skip        = cycle_skip_q;
  assign nonzero_count     = nonzero_count_q;
  assign skip_count        = skip_count_q;
  assign layer_done        = layer_done_q;
  assign busy              = busy_q;
  assign err_flags         = err_flags_q;

endmodule

// File: tb/tb_sparsity_sched_ctrl.sv
// Directed bench for sparsity_sched_ctrl: vector table for the nominal layer, hand sequences for corners.
module tb_sparsity_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        layer_start, abort, act_tvalid, wt_tvalid, sparsity_tvalid;
  logic [15:0] preamble_cycle_length, integration_cycles, sparsity_tdata;
  logic        state_changed, integration_start, cycle_skip, layer_done, busy;
  logic [15:0] lane_enable, skip_count;
  logic [31:0] nonzero_count;
  logic [1:0]  err_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sparsity_sched_ctrl #(
    .CYCLE_SAMPLE_NUM (16),
    .DRAIN_CYCLES     (4),
    .TIMEOUT_CYCLES   (8)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .layer_start           (layer_start),
    .abort                 (abort),
    .preamble_cycle_length (preamble_cycle_length),
    .integration_cycles    (integration_cycles),
    .act_tvalid            (act_tvalid),
    .wt_tvalid             (wt_tvalid),
    .sparsity_tdata        (sparsity_tdata),
    .sparsity_tvalid       (sparsity_tvalid),
    .state_changed         (state_changed),
    .integration_start     (integration_start),
    .lane_enable           (lane_enable),
    .cycle_skip            (cycle_skip),
    .nonzero_count         (nonzero_count),
    .skip_count            (skip_count),
    .layer_done            (layer_done),
    .busy                  (busy),
    .err_flags             (err_flags)
  );

  typedef struct {
    logic        ls, act, wt, sv;
    logic [15:0] sd;
    logic [15:0] lane;
    logic        sc, is, cs, dn, bz;
    logic [31:0] nz;
    logic [15:0] sk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ls, input logic act, input logic wt, input logic sv,
                     input logic [15:0] sd, input logic [15:0] lane,
                     input logic sc, input logic is, input logic cs, input logic dn,
                     input logic bz, input logic [31:0] nz, input logic [15:0] sk);
    vec_t v;
    v.ls = ls; v.act = act; v.wt = wt; v.sv = sv; v.sd = sd; v.lane = lane;
    v.sc = sc; v.is = is; v.cs = cs; v.dn = dn; v.bz = bz; v.nz = nz; v.sk = sk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (layer_done !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic clear_inputs();
    layer_start = 1'b0; abort = 1'b0; act_tvalid = 1'b0; wt_tvalid = 1'b0;
    sparsity_tvalid = 1'b0; sparsity_tdata = 16'h0;
  endtask

  int  n;
  int  beats;
  logic seen;

  initial begin
    clear_inputs();
    preamble_cycle_length = 16'd3;
    integration_cycles    = 16'd4;
    rst_n = 1'b0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_lane", 32'(lane_enable), 32'd0);
    chk("reset_nz", nonzero_count, 32'd0);
    chk("reset_err", 32'(err_flags), 32'd0);
    chk("reset_done", 32'(layer_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Nominal layer: preamble 3, four beats FFFF,0000,00F0,8001 with a gap, drain 4.
    //   ls   act  wt   sv   sd        lane      sc   is   cs   dn   bz   nz      sk
    add(1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b0,1'b0,1'b1,16'hFFFF,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0, 16'd0);
    add(1'b0,1'b0,1'b0,1'b1,16'hFFFF,16'hFFFF,1'b0,1'b0,1'b0,1'b0,1'b1,32'd16,16'd0);
    add(1'b0,1'b0,1'b0,1'b0,16'hFFFF,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd16,16'd0);
    add(1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b1,32'd16,16'd1);
    add(1'b0,1'b0,1'b0,1'b1,16'h00F0,16'h00F0,1'b0,1'b0,1'b0,1'b0,1'b1,32'd20,16'd1);
    add(1'b0,1'b0,1'b0,1'b1,16'h8001,16'h8001,1'b0,1'b0,1'b0,1'b0,1'b1,32'd22,16'd1);
    add(1'b0,1'b0,1'b0,1'b1,16'hFFFF,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd22,16'd1);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd22,16'd1);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,32'd22,16'd1);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b1,32'd22,16'd1);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,32'd22,16'd1);

    foreach (tbl[i]) begin
      layer_start = tbl[i].ls; act_tvalid = tbl[i].act; wt_tvalid = tbl[i].wt;
      sparsity_tvalid = tbl[i].sv; sparsity_tdata = tbl[i].sd;
      step();
      chk($sformatf("v%0d_lane", i), 32'(lane_enable), 32'(tbl[i].lane));
      chk($sformatf("v%0d_state_changed", i), 32'(state_changed), 32'(tbl[i].sc));
      chk($sformatf("v%0d_int_start", i), 32'(integration_start), 32'(tbl[i].is));
      chk($sformatf("v%0d_cycle_skip", i), 32'(cycle_skip), 32'(tbl[i].cs));
      chk($sformatf("v%0d_layer_done", i), 32'(layer_done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("v%0d_nz", i), nonzero_count, tbl[i].nz);
      chk($sformatf("v%0d_skip", i), 32'(skip_count), 32'(tbl[i].sk));
    end
    clear_inputs();
    chk("nominal_err", 32'(err_flags), 32'd0);

    // Preamble 3 again, counting valid beats seen before integration_start.
    layer_start = 1'b1; step(); layer_start = 1'b0;
    beats = 0; n = 0;
    while (integration_start !== 1'b1 && n < 20) begin
      act_tvalid = (n % 2 == 0); wt_tvalid = 1'b1;
      if (act_tvalid) beats++;
      step(); n++;
      if (integration_start === 1'b1 && act_tvalid) beats--;
    end
    act_tvalid = 1'b0; wt_tvalid = 1'b0;
    chk("pre3_int_start_seen", 32'(integration_start), 32'd1);
    chk("pre3_beats_before_start", 32'(beats), 32'd3);
    abort = 1'b1; step(); abort = 1'b0;

    // Zero preamble and zero integration length: one beat consumed.
    preamble_cycle_length = 16'd0; integration_cycles = 16'd0;
    layer_start = 1'b1; step(); layer_start = 1'b0;
    chk("t2_state_changed", 32'(state_changed), 32'd1);
    step();
    chk("t2_int_start", 32'(integration_start), 32'd1);
    sparsity_tvalid = 1'b1; sparsity_tdata = 16'h0003;
    step();
    chk("t2_arm_beat_dropped", nonzero_count, 32'd0);
    step();
    chk("t2_one_beat_nz", nonzero_count, 32'd2);
    chk("t2_lane", 32'(lane_enable), 32'h0003);
    step();
    chk("t2_no_second_beat", nonzero_count, 32'd2);
    sparsity_tvalid = 1'b0;
    wait_done(10, n);
    chk("t2_layer_done", 32'(layer_done), 32'd1);
    step();
    chk("t2_idle", 32'(busy), 32'd0);

    // Gap returns lanes to 0, then idle timeout after 8 empty cycles.
    integration_cycles = 16'd3;
    layer_start = 1'b1; step(); layer_start = 1'b0;
    step(); step();
    sparsity_tvalid = 1'b1; sparsity_tdata = 16'h00FF; step();
    chk("t3_lane_beat", 32'(lane_enable), 32'h00FF);
    sparsity_tvalid = 1'b0; step();
    chk("t3_lane_gap", 32'(lane_enable), 32'd0);
    chk("t3_err_before", 32'(err_flags), 32'd0);
    wait_done(20, n);
    chk("t3_timeout_cycles", 32'(n), 32'd7);
    chk("t3_done", 32'(layer_done), 32'd1);
    chk("t3_err_timeout", 32'(err_flags), 32'd1);
    step();
    chk("t3_back_idle", 32'(busy), 32'd0);

    // layer_start while integrating is ignored and flagged.
    integration_cycles = 16'd2;
    layer_start = 1'b1; step(); layer_start = 1'b0;
    step(); step();
    sparsity_tvalid = 1'b1; sparsity_tdata = 16'h000F; layer_start = 1'b1; step();
    layer_start = 1'b0;
    chk("t4_no_state_changed", 32'(state_changed), 32'd0);
    chk("t4_err_busy_start", 32'(err_flags), 32'd3);
    chk("t4_nz_1", nonzero_count, 32'd4);
    sparsity_tdata = 16'h0F00; step();
    chk("t4_nz_2", nonzero_count, 32'd8);
    sparsity_tvalid = 1'b0;
    wait_done(10, n);
    chk("t4_done", 32'(layer_done), 32'd1);
    step();
    layer_start = 1'b1; step(); layer_start = 1'b0;
    chk("t4_restart_sc", 32'(state_changed), 32'd1);
    chk("t4_restart_nz_clear", nonzero_count, 32'd0);
    chk("t4_err_kept", 32'(err_flags), 32'd3);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_abort_preamble", 32'(busy), 32'd0);

    // Abort mid-integration: immediate idle, lanes off, counts held, no done.
    integration_cycles = 16'd5;
    layer_start = 1'b1; step(); layer_start = 1'b0;
    step(); step();
    sparsity_tvalid = 1'b1; sparsity_tdata = 16'hFFFF; step();
    chk("t5_lane_before_abort", 32'(lane_enable), 32'hFFFF);
    abort = 1'b1; step(); abort = 1'b0; sparsity_tvalid = 1'b0;
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_lane", 32'(lane_enable), 32'd0);
    chk("t5_abort_nz_hold", nonzero_count, 32'd16);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (layer_done === 1'b1) seen = 1'b1;
    end
    chk("t5_abort_no_done", 32'(seen), 32'd0);

    // Reset mid-preamble takes effect without a clock edge.
    preamble_cycle_length = 16'd5;
    layer_start = 1'b1; step(); layer_start = 1'b0;
    act_tvalid = 1'b1; wt_tvalid = 1'b1; step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_err", 32'(err_flags), 32'd0);
    chk("t5_rst_nz", nonzero_count, 32'd0);
    chk("t5_rst_done", 32'(layer_done), 32'd0);
    act_tvalid = 1'b0; wt_tvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("t5_post_rst_idle", 32'(busy), 32'd0);

    // Saturation of nonzero_count from a preloaded near-max value.
    preamble_cycle_length = 16'd0; integration_cycles = 16'd6;
    layer_start = 1'b1; step(); layer_start = 1'b0;
    step(); step();
    force dut.nonzero_count_q = 32'hFFFF_FFF0;
    #1 release dut.nonzero_count_q;
    chk("t6_preload", nonzero_count, 32'hFFFF_FFF0);
    sparsity_tvalid = 1'b1; sparsity_tdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_sat_%0d", i), nonzero_count, 32'hFFFF_FFFF);
    end
    sparsity_tvalid = 1'b0;
    wait_done(30, n);
    chk("t6_done", 32'(layer_done), 32'd1);
    chk("t6_sat_hold", nonzero_count, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
